pcie_link_train_seq: RTL and testbench
======================================

Name: pcie_link_train_seq

Overview:
- Parametrised multi-lane link-bring-up sequencer for the PCIe BFM harness.
- Sequence after PERST_n release: reset hold-off, receiver detect, per-lane electrical-idle exit, width negotiation (with optional lane reversal), then L0.
- Handles retrain/recovery while in L0.
- Drives per-lane electrical-idle controls to the lane models and reports link status to the testbench.

Parameters:
- LINK_WIDTH, 1: max lanes; legal 1, 2, 4, 8, 16.
- PERST_DLY, 100: cycles to hold after PERST_n high before detect.
- DETECT_TO, 64: detect window length in cycles.
- IDLE_EXIT, 16: consecutive all-lanes-locked cycles required to leave POLLING/RECOVERY.
- POLL_TO, 1024: POLLING/RECOVERY timeout in cycles.
- SUPPORT_REVERSAL, 1: 1 = allow reversed lane ordering during negotiation.

Ports:
- CLK, input, 1: sole clock; all logic rising-edge.
- PERST_n, input, 1: synchronous active-low reset.
- rx_present, input, LINK_WIDTH: per-lane receiver-detected indication, sampled in DETECT.
- rx_ts_ok, input, LINK_WIDTH: per-lane training-set lock.
- train_req, input, 1: single-cycle retrain request.
- tx_elec_idle, output, LINK_WIDTH: 1 = lane held in electrical idle.
- tx_detect_en, output, 1: receiver-detect pulse enable.
- ltssm_state, output, 3: current state encoding.
- link_up, output, 1: high only in L0.
- nego_width, output, $clog2(LINK_WIDTH)+1: negotiated lane count; 0 = unconfigured.
- lane_reversed, output, 1: negotiated link uses the top lanes, reversed.
- err_timeout, output, 1: sticky; set on any POLLING/RECOVERY timeout.
- detect_retries, output, 4: saturating count of empty detect windows.

Behaviour:
- Reset: PERST_n=0 sampled at a CLK edge wins over every other input. It forces:
  - ltssm_state=RESET_WAIT(0), tx_elec_idle=all 1, tx_detect_en=0, link_up=0
  - nego_width=0, lane_reversed=0, err_timeout=0, detect_retries=0
  - cycle counter=0, det_mask=0, lock counter=0
- States: RESET_WAIT=0, DETECT=1, POLLING=2, CONFIG=3, L0=4, RECOVERY=5; 6 and 7 are unused and decode to RESET_WAIT.
- RESET_WAIT: counter increments every cycle. After PERST_DLY edges with PERST_n=1, go to DETECT (counter cleared).
- DETECT:
  - tx_detect_en=1, all lanes idle.
  - On the DETECT_TO-th cycle, det_mask<=rx_present.
  - If rx_present==0: stay in DETECT, restart the window, detect_retries++ (saturates at 15).
  - Otherwise go to POLLING.
- POLLING:
  - tx_detect_en=0; tx_elec_idle=~det_mask.
  - Lock counter increments while (rx_ts_ok & det_mask)==det_mask, and clears otherwise.
  - Lock counter reaching IDLE_EXIT → CONFIG.
  - POLL_TO cycles in state → DETECT, err_timeout<=1.
- CONFIG (exactly 1 cycle):
  - n = largest power of two ≤ LINK_WIDTH with det_mask[n-1:0] all 1.
  - r = same test on det_mask[LINK_WIDTH-1:LINK_WIDTH-n]; r only evaluated if SUPPORT_REVERSAL=1.
  - Pick the larger of n and r; a tie chooses normal ordering.
  - If neither exists → DETECT.
  - Otherwise register nego_width and lane_reversed, and set tx_elec_idle=1 on non-negotiated lanes (active_mask). Next state L0.
- L0:
  - link_up=1.
  - train_req=1, or any active lane with rx_ts_ok=0 → RECOVERY next cycle. link_up drops the same edge.
  - train_req is ignored in every state except L0.
- RECOVERY:
  - Same lock/timeout rule as POLLING, applied over active_mask.
  - Success → L0 with width and reversal retained.
  - Timeout → DETECT, err_timeout<=1, nego_width<=0.
- Simultaneous events: a timeout and a lock completion on the same cycle resolve as lock wins.
- Counters are wide enough for max(PERST_DLY, POLL_TO) and never wrap; all are cleared on every state entry.

Decomposition:
- Package pcie_seq_pkg holds:
  - the ltssm_state enum with fixed encodings;
  - the width-negotiation function (det_mask, LINK_WIDTH, SUPPORT_REVERSAL) → {width, reversed};
  - the legal-width constant list.
- One sub-module, pcie_lane_lock_timer: lock counter plus timeout counter, shared by POLLING and RECOVERY.
  - Inputs: enable, mask, rx_ts_ok.
  - Outputs: locked pulse, timeout pulse.

Test Plan:
All cases use LINK_WIDTH=4, PERST_DLY=8, DETECT_TO=4, IDLE_EXIT=2, POLL_TO=16, with rx_ts_ok following tx_elec_idle after 1 cycle unless stated.
- Nominal bring-up: rx_present=4'hF → DETECT after 8 cycles; L0 with nego_width=4, lane_reversed=0, tx_elec_idle=0.
- Partial detect: rx_present=4'b0111 → nego_width=2, lane_reversed=0, tx_elec_idle=4'b1100.
- Reversal: rx_present=4'b1100 → nego_width=2, lane_reversed=1. With SUPPORT_REVERSAL=0, the same mask → CONFIG→DETECT loop and link_up stays 0.
- Empty detect: rx_present=0 for 3 windows → detect_retries=3, state stays 1. Then 4'hF → L0.
- Retrain/timeout:
  - train_req pulse in L0 → RECOVERY and back to L0 with width kept.
  - With rx_ts_ok held at 0: after 16 cycles → DETECT, err_timeout=1, nego_width=0.
- Reset mid-operation: PERST_n=0 for 1 cycle while in L0 → next edge shows all reset values. Re-training then restarts from RESET_WAIT.

Source files
------------

// File: rtl/pcie_seq_pkg.sv
// Shared types and helpers for the PCIe BFM link-training sequencer:
// LTSSM state encoding, legal lane widths and the width-negotiation rule.
package pcie_seq_pkg;

    typedef enum logic [2:0] {
        RESET_WAIT = 3'd0,
        DETECT     = 3'd1,
        POLLING    = 3'd2,
        CONFIG     = 3'd3,
        L0         = 3'd4,
        RECOVERY   = 3'd5
    } ltssm_e;

    localparam int MAX_LANES        = 16;
    localparam int NUM_LEGAL_WIDTHS = 5;
    localparam int LEGAL_WIDTHS [NUM_LEGAL_WIDTHS] = '{1, 2, 4, 8, 16};

    typedef struct packed {
        logic [4:0] width;
        logic       reversed;
    } nego_t;

    // Widest contiguous block anchored at lane 0 (normal) or at the top lane
    // (reversed); on a tie the normal ordering is kept. Width 0 = no link.
    function automatic nego_t negotiate_width(input logic [MAX_LANES-1:0] det_mask,
                                              input int link_width,
                                              input bit allow_rev);
        nego_t                res;
        int                   n_w;
        int                   r_w;
        logic [MAX_LANES-1:0] low;
        logic [MAX_LANES-1:0] high;
        n_w = 0;
        r_w = 0;
        for (int i = 0; i < NUM_LEGAL_WIDTHS; i++) begin
            if (LEGAL_WIDTHS[i] <= link_width) begin
                low  = {MAX_LANES{1'b1}} >> (MAX_LANES - LEGAL_WIDTHS[i]);
                high = low << (link_width - LEGAL_WIDTHS[i]);
                if ((det_mask & low) == low) n_w = LEGAL_WIDTHS[i];
                if (allow_rev && ((det_mask & high) == high)) r_w = LEGAL_WIDTHS[i];
            end
        end
        if (r_w > n_w) begin
            res.width    = 5'(r_w);
            res.reversed = 1'b1;
        end else begin
            res.width    = 5'(n_w);
            res.reversed = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/pcie_lane_lock_timer.sv
// Consecutive-lock counter plus in-state timeout counter, shared by
// POLLING and RECOVERY. Both counters sit at zero whenever disabled.
module pcie_lane_lock_timer #(
    parameter int LINK_WIDTH = 1,
    parameter int IDLE_EXIT  = 16,
    parameter int POLL_TO    = 1024
) (
    input  logic                  CLK,
    input  logic                  PERST_n,
    input  logic                  enable,
    input  logic [LINK_WIDTH-1:0] mask,
    input  logic [LINK_WIDTH-1:0] rx_ts_ok,
    output logic                  locked,
    output logic                  timeout
);

    localparam int LCW = $clog2(IDLE_EXIT + 1);
    localparam int TCW = $clog2(POLL_TO + 1);

    logic [LCW-1:0] lock_cnt;
    logic [TCW-1:0] age_cnt;
    logic           all_ok;

    assign all_ok = (rx_ts_ok & mask) == mask;
    assign locked = enable && all_ok && (lock_cnt == LCW'(IDLE_EXIT - 1));
    // A lock completing on the timeout cycle takes priority.
    assign timeout = enable && !locked && (age_cnt == TCW'(POLL_TO - 1));

    always_ff @(posedge CLK) begin
        if (!PERST_n || !enable || locked || timeout) begin
            lock_cnt <= '0;
            age_cnt  <= '0;
        end else begin
            age_cnt  <= age_cnt + TCW'(1);
            lock_cnt <= all_ok ? lock_cnt + LCW'(1) : '0;
        end
    end

endmodule

// File: rtl/pcie_link_train_seq.sv
// Multi-lane link bring-up sequencer: reset hold-off, receiver detect,
// lane lock, width negotiation (optionally reversed), L0 and recovery.
module pcie_link_train_seq
    import pcie_seq_pkg::*;
#(
    parameter int LINK_WIDTH       = 1,
    parameter int PERST_DLY        = 100,
    parameter int DETECT_TO        = 64,
    parameter int IDLE_EXIT        = 16,
    parameter int POLL_TO          = 1024,
    parameter int SUPPORT_REVERSAL = 1
) (
    input  logic                          CLK,
    input  logic                          PERST_n,
    input  logic [LINK_WIDTH-1:0]         rx_present,
    input  logic [LINK_WIDTH-1:0]         rx_ts_ok,
    input  logic                          train_req,
    output logic [LINK_WIDTH-1:0]         tx_elec_idle,
    output logic                          tx_detect_en,
    output logic [2:0]                    ltssm_state,
    output logic                          link_up,
    output logic [$clog2(LINK_WIDTH):0]   nego_width,
    output logic                          lane_reversed,
    output logic                          err_timeout,
    output logic [3:0]                    detect_retries
);

    localparam int NW      = $clog2(LINK_WIDTH) + 1;
    localparam int CNT_MAX = (PERST_DLY > DETECT_TO) ? PERST_DLY : DETECT_TO;
    localparam int CW      = $clog2(CNT_MAX + 1);

    ltssm_e                state;
    ltssm_e                next_state;
    logic [CW-1:0]         cnt;
    logic [LINK_WIDTH-1:0] det_mask;
    logic [LINK_WIDTH-1:0] active_mask;
    logic [LINK_WIDTH-1:0] timer_mask;
    logic                  timer_en;
    logic                  locked;
    logic                  timeout;
    logic                  det_done;
    nego_t                 nego;
    int                    nw_int;

    assign det_done    = (cnt == CW'(DETECT_TO - 1));
    assign nego        = negotiate_width(MAX_LANES'(det_mask), LINK_WIDTH, SUPPORT_REVERSAL != 0);
    assign nw_int      = int'(nego_width);
    assign ltssm_state = state;

    // Lanes carrying the negotiated link: bottom lanes, or top lanes when reversed.
    always_comb begin
        active_mask = '0;
        for (int i = 0; i < LINK_WIDTH; i++) begin
            if (lane_reversed) active_mask[i] = (i >= LINK_WIDTH - nw_int);
            else               active_mask[i] = (i < nw_int);
        end
    end

    pcie_lane_lock_timer #(
        .LINK_WIDTH (LINK_WIDTH),
        .IDLE_EXIT  (IDLE_EXIT),
        .POLL_TO    (POLL_TO)
    ) u_lock_timer (
        .CLK      (CLK),
        .PERST_n  (PERST_n),
        .enable   (timer_en),
        .mask     (timer_mask),
        .rx_ts_ok (rx_ts_ok),
        .locked   (locked),
        .timeout  (timeout)
    );

    always_ff @(posedge CLK) begin
        if (!PERST_n) state <= RESET_WAIT;
        else          state <= next_state;
    end

    always_comb begin
        next_state   = state;
        tx_detect_en = 1'b0;
        link_up      = 1'b0;
        tx_elec_idle = '1;
        timer_en     = 1'b0;
        timer_mask   = det_mask;
        case (state)
            RESET_WAIT: if (cnt == CW'(PERST_DLY - 1)) next_state = DETECT;
            DETECT: begin
                tx_detect_en = 1'b1;
                if (det_done && rx_present != '0) next_state = POLLING;
            end
            POLLING: begin
                tx_elec_idle = ~det_mask;
                timer_en     = 1'b1;
                if (locked)       next_state = CONFIG;
                else if (timeout) next_state = DETECT;
            end
            CONFIG: begin
                tx_elec_idle = ~det_mask;
                next_state   = (nego.width == 5'd0) ? DETECT : L0;
            end
            L0: begin
                tx_elec_idle = ~active_mask;
                link_up      = 1'b1;
                if (train_req || |(active_mask & ~rx_ts_ok)) next_state = RECOVERY;
            end
            RECOVERY: begin
                tx_elec_idle = ~active_mask;
                timer_en     = 1'b1;
                timer_mask   = active_mask;
                if (locked)       next_state = L0;
                else if (timeout) next_state = DETECT;
            end
            default: next_state = RESET_WAIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!PERST_n) begin
            cnt            <= '0;
            det_mask       <= '0;
            nego_width     <= '0;
            lane_reversed  <= 1'b0;
            err_timeout    <= 1'b0;
            detect_retries <= '0;
        end else begin
            // An empty detect window restarts just like a fresh state entry.
            if (next_state != state || (state == DETECT && det_done))
                cnt <= '0;
            else if (state == RESET_WAIT || state == DETECT)
                cnt <= cnt + CW'(1);

            if (state == DETECT && det_done) begin
                det_mask <= rx_present;
                if (rx_present == '0 && detect_retries != 4'hF)
                    detect_retries <= detect_retries + 4'd1;
            end

            if (state == CONFIG && nego.width != 5'd0) begin
                nego_width    <= NW'(nego.width);
                lane_reversed <= nego.reversed;
            end

            if ((state == POLLING || state == RECOVERY) && timeout)
                err_timeout <= 1'b1;
            if (state == RECOVERY && timeout)
                nego_width <= '0;
        end
    end

endmodule

// File: tb/tb_pcie_link_train_seq.sv
// Bench for pcie_link_train_seq: two instances (reversal on/off) checked every
// cycle against a phase/age reference model, plus directed literal checks.
module tb_pcie_link_train_seq;

    localparam int LW = 4;
    localparam int PD = 8;
    localparam int DT = 4;
    localparam int IE = 2;
    localparam int PT = 16;

    logic       CLK = 1'b0;
    logic       PERST_n;
    logic [3:0] rx_present;
    logic [3:0] rx_ts_ok;
    logic       train_req;

    logic [3:0] r_idle, n_idle;
    logic       r_det_en, n_det_en;
    logic [2:0] r_state, n_state;
    logic       r_link, n_link;
    logic [2:0] r_nw, n_nw;
    logic       r_rev, n_rev;
    logic       r_err, n_err;
    logic [3:0] r_retry, n_retry;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit ts_zero = 1'b0;
    logic [3:0] last_idle = 4'hF;
    logic [3:0] glitch = 4'h0;

    // Reference model: index 0 = reversal allowed, index 1 = not allowed.
    int         m_state [2];
    int         m_age   [2];
    int         m_run   [2];
    int         m_w     [2];
    int         m_retry [2];
    logic [3:0] m_det   [2];
    bit         m_rev   [2];
    bit         m_err   [2];

    always #5 CLK = ~CLK;

    pcie_link_train_seq #(.LINK_WIDTH(LW), .PERST_DLY(PD), .DETECT_TO(DT), .IDLE_EXIT(IE),
                          .POLL_TO(PT), .SUPPORT_REVERSAL(1)) dut_r (
        .CLK(CLK), .PERST_n(PERST_n), .rx_present(rx_present), .rx_ts_ok(rx_ts_ok),
        .train_req(train_req), .tx_elec_idle(r_idle), .tx_detect_en(r_det_en),
        .ltssm_state(r_state), .link_up(r_link), .nego_width(r_nw),
        .lane_reversed(r_rev), .err_timeout(r_err), .detect_retries(r_retry));

    pcie_link_train_seq #(.LINK_WIDTH(LW), .PERST_DLY(PD), .DETECT_TO(DT), .IDLE_EXIT(IE),
                          .POLL_TO(PT), .SUPPORT_REVERSAL(0)) dut_n (
        .CLK(CLK), .PERST_n(PERST_n), .rx_present(rx_present), .rx_ts_ok(rx_ts_ok),
        .train_req(train_req), .tx_elec_idle(n_idle), .tx_detect_en(n_det_en),
        .ltssm_state(n_state), .link_up(n_link), .nego_width(n_nw),
        .lane_reversed(n_rev), .err_timeout(n_err), .detect_retries(n_retry));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pow2_floor(input int t);
        int p;
        if (t < 1) return 0;
        p = 1;
        while (p * 2 <= t) p = p * 2;
        return p;
    endfunction

    function automatic logic [3:0] model_active(input int w, input bit rev);
        logic [3:0] a;
        a = 4'h0;
        for (int i = 0; i < LW; i++)
            if (rev ? (i >= LW - w) : (i < w)) a[i] = 1'b1;
        return a;
    endfunction

    task automatic enter(input int k, input int s);
        m_state[k] = s;
        m_age[k]   = 0;
        m_run[k]   = 0;
    endtask

    task automatic model_step(input int k, input bit rev_en);
        logic [3:0] msk;
        int         lo, hi, n, r;
        if (!PERST_n) begin
            enter(k, 0);
            m_det[k] = 4'h0; m_w[k] = 0; m_rev[k] = 1'b0; m_err[k] = 1'b0; m_retry[k] = 0;
        end else begin
            case (m_state[k])
                0: begin
                    m_age[k]++;
                    if (m_age[k] == PD) enter(k, 1);
                end
                1: begin
                    m_age[k]++;
                    if (m_age[k] == DT) begin
                        m_det[k] = rx_present;
                        if (rx_present == 4'h0) begin
                            if (m_retry[k] < 15) m_retry[k]++;
                            m_age[k] = 0;
                        end else enter(k, 2);
                    end
                end
                2, 5: begin
                    msk = (m_state[k] == 2) ? m_det[k] : model_active(m_w[k], m_rev[k]);
                    m_run[k] = ((rx_ts_ok & msk) == msk) ? m_run[k] + 1 : 0;
                    m_age[k]++;
                    if (m_run[k] == IE) enter(k, (m_state[k] == 2) ? 3 : 4);
                    else if (m_age[k] == PT) begin
                        m_err[k] = 1'b1;
                        if (m_state[k] == 5) m_w[k] = 0;
                        enter(k, 1);
                    end
                end
                3: begin
                    lo = 0;
                    while (lo < LW && m_det[k][lo]) lo++;
                    hi = 0;
                    while (hi < LW && m_det[k][LW-1-hi]) hi++;
                    n = pow2_floor(lo);
                    r = rev_en ? pow2_floor(hi) : 0;
                    if (n == 0 && r == 0) enter(k, 1);
                    else begin
                        m_w[k]   = (r > n) ? r : n;
                        m_rev[k] = (r > n);
                        enter(k, 4);
                    end
                end
                4: if (train_req || (model_active(m_w[k], m_rev[k]) & ~rx_ts_ok) != 4'h0) enter(k, 5);
                default: enter(k, 0);
            endcase
        end
    endtask

    task automatic compare(input int k, input string t, input logic [2:0] st, input logic de,
                           input logic [3:0] idle, input logic lu, input logic [2:0] nw,
                           input logic lr, input logic er, input logic [3:0] rt);
        logic [3:0] exp_idle;
        case (m_state[k])
            0, 1:    exp_idle = 4'hF;
            2, 3:    exp_idle = ~m_det[k];
            default: exp_idle = ~model_active(m_w[k], m_rev[k]);
        endcase
        chk({t, ".state"},     32'(st),   32'(m_state[k]));
        chk({t, ".detect_en"}, 32'(de),   32'(m_state[k] == 1));
        chk({t, ".elec_idle"}, 32'(idle), 32'(exp_idle));
        chk({t, ".link_up"},   32'(lu),   32'(m_state[k] == 4));
        chk({t, ".nego_w"},    32'(nw),   32'(m_w[k]));
        chk({t, ".reversed"},  32'(lr),   32'(m_rev[k]));
        chk({t, ".err_to"},    32'(er),   32'(m_err[k]));
        chk({t, ".retries"},   32'(rt),   32'(m_retry[k]));
    endtask

    // One clock: advance the model at the edge, compare at the falling edge,
    // then drive the next cycle's inputs (lanes answer one cycle behind idle).
    task automatic cyc();
        @(posedge CLK);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        @(negedge CLK);
        if (chk_en) begin
            compare(0, "rev",   r_state, r_det_en, r_idle, r_link, r_nw, r_rev, r_err, r_retry);
            compare(1, "norev", n_state, n_det_en, n_idle, n_link, n_nw, n_rev, n_err, n_retry);
        end
        train_req = 1'b0;
        rx_ts_ok  = ts_zero ? 4'h0 : (~last_idle & ~glitch);
        glitch    = 4'h0;
        last_idle = r_idle;
    endtask

    task automatic wait_state(input string nm, input int target, input int budget);
        int n;
        n = 0;
        while (int'(r_state) != target && n < budget) begin
            cyc();
            n++;
        end
        chk(nm, 32'(r_state), 32'(target));
    endtask

    initial begin
        int n;
        int n_cfg;
        int n_lu;
        int len;
        int zero_left;
        PERST_n    = 1'b0;
        rx_present = 4'hF;
        rx_ts_ok   = 4'h0;
        train_req  = 1'b0;
        chk_en     = 1'b1;
        cyc();
        cyc();
        chk("reset.state",   32'(r_state), 32'd0);
        chk("reset.idle",    32'(r_idle),  32'hF);
        chk("reset.det_en",  32'(r_det_en), 32'd0);
        chk("reset.link",    32'(r_link),  32'd0);
        chk("reset.retries", 32'(r_retry), 32'd0);

        // Nominal bring-up, exact hold-off length.
        PERST_n = 1'b1;
        repeat (7) cyc();
        chk("holdoff.still_reset", 32'(r_state), 32'd0);
        cyc();
        chk("holdoff.detect", 32'(r_state), 32'd1);
        chk("holdoff.det_en", 32'(r_det_en), 32'd1);
        wait_state("nominal.l0", 4, 100);
        chk("nominal.width", 32'(r_nw),   32'd4);
        chk("nominal.rev",   32'(r_rev),  32'd0);
        chk("nominal.idle",  32'(r_idle), 32'h0);
        chk("nominal.link",  32'(r_link), 32'd1);
        chk("nominal.norev_l0", 32'(n_state), 32'd4);

        // Retrain request.
        train_req = 1'b1;
        cyc();
        chk("retrain.recovery", 32'(r_state), 32'd5);
        chk("retrain.link_drop", 32'(r_link), 32'd0);
        wait_state("retrain.l0", 4, 50);
        chk("retrain.width", 32'(r_nw), 32'd4);

        // Recovery timeout with lanes dead.
        ts_zero = 1'b1;
        wait_state("timeout.recovery", 5, 5);
        n = 0;
        while (r_state == 3'd5 && n < 40) begin
            cyc();
            n++;
        end
        chk("timeout.cycles", 32'(n), 32'd16);
        chk("timeout.detect", 32'(r_state), 32'd1);
        chk("timeout.err",    32'(r_err),   32'd1);
        chk("timeout.width",  32'(r_nw),    32'd0);
        ts_zero = 1'b0;
        wait_state("timeout.relink", 4, 100);

        // Reset while in L0.
        PERST_n = 1'b0;
        cyc();
        chk("midreset.state", 32'(r_state), 32'd0);
        chk("midreset.idle",  32'(r_idle),  32'hF);
        chk("midreset.width", 32'(r_nw),    32'd0);
        chk("midreset.err",   32'(r_err),   32'd0);
        chk("midreset.link",  32'(r_link),  32'd0);

        // Partial detect.
        PERST_n    = 1'b1;
        rx_present = 4'b0111;
        wait_state("partial.l0", 4, 100);
        chk("partial.width", 32'(r_nw),   32'd2);
        chk("partial.rev",   32'(r_rev),  32'd0);
        chk("partial.idle",  32'(r_idle), 32'b1100);

        // Reversal, and the no-reversal instance looping CONFIG->DETECT.
        PERST_n    = 1'b0;
        rx_present = 4'b1100;
        cyc();
        PERST_n = 1'b1;
        n_cfg = 0;
        n_lu  = 0;
        repeat (80) begin
            cyc();
            if (n_state == 3'd3) n_cfg++;
            if (n_link) n_lu++;
        end
        chk("reversal.l0",    32'(r_state), 32'd4);
        chk("reversal.width", 32'(r_nw),    32'd2);
        chk("reversal.rev",   32'(r_rev),   32'd1);
        chk("reversal.idle",  32'(r_idle),  32'b0011);
        chk("norev.link_seen",   32'(n_lu),      32'd0);
        chk("norev.config_seen", 32'(n_cfg > 0), 32'd1);

        // Empty detect windows, then saturation, then a real link.
        PERST_n    = 1'b0;
        rx_present = 4'h0;
        cyc();
        PERST_n = 1'b1;
        repeat (PD + 3 * DT) cyc();
        chk("empty.retries3", 32'(r_retry), 32'd3);
        chk("empty.state",    32'(r_state), 32'd1);
        repeat (60) cyc();
        chk("empty.saturate", 32'(r_retry), 32'd15);
        rx_present = 4'hF;
        wait_state("empty.l0", 4, 100);
        chk("empty.width", 32'(r_nw), 32'd4);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            rx_present = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            PERST_n = 1'b0;
            cyc();
            PERST_n   = 1'b1;
            zero_left = 0;
            len = int'($urandom_range(60, 220));
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 15) == 0) train_req = 1'b1;
                if ($urandom_range(0, 24) == 0) glitch = 4'($urandom_range(1, 15));
                if ($urandom_range(0, 39) == 0) rx_present = 4'($urandom_range(0, 15));
                if (zero_left == 0 && $urandom_range(0, 99) == 0) zero_left = int'($urandom_range(5, 25));
                ts_zero = (zero_left > 0);
                if (zero_left > 0) zero_left--;
                PERST_n = ($urandom_range(0, 199) != 0);
                cyc();
            end
            ts_zero = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
